// File: rtl/mul_issue_sched.sv
// Round-robin issue scheduler for the shared 32x32 multiplier between two pipes.
// E1 registers operands in front of the multiplier and E2 captures the result.
// Optional statistics counters are enabled with `define MUL_SCHED_STAT_EN.
module mul_issue_sched #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_sign,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  input  logic [63:0]      mul_r,
  output logic             busy,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_conflict
);

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  logic             e1_valid, e1_src;
  op_e              e1_op;
  logic [TAG_W-1:0] e1_tag;
  logic [31:0]      e1_a, e1_b;

  logic             e2_valid, e2_src;
  logic [TAG_W-1:0] e2_tag;
  logic [31:0]      e2_data;

  logic             rr_ptr;
  logic             e1_adv, e2_adv;
  logic [1:0]       grant;
  logic             gnt_src;
  op_e              sel_op;
  logic [31:0]      sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      e1_result;

  assign e2_adv = ~e2_valid | resp_ready[e2_src];
  assign e1_adv = ~e1_valid | e2_adv;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (e1_adv && !flush) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign gnt_src   = grant[1];
  assign sel_op    = op_e'(gnt_src ? req_op1 : req_op0);
  assign sel_a     = gnt_src ? req_a1   : req_a0;
  assign sel_b     = gnt_src ? req_b1   : req_b0;
  assign sel_tag   = gnt_src ? req_tag1 : req_tag0;

  // Reserved op 11 falls into the low-word path, identical to mul.w.
  assign e1_result = (e1_op == OP_MULH || e1_op == OP_MULHU) ? mul_r[63:32] : mul_r[31:0];

  assign mul_x = e1_a;
  assign mul_y = e1_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_valid <= 1'b0;
      e1_src   <= 1'b0;
      e1_op    <= OP_MUL;
      e1_tag   <= '0;
      e1_a     <= '0;
      e1_b     <= '0;
      mul_sign <= 1'b0;
      e2_valid <= 1'b0;
      e2_src   <= 1'b0;
      e2_tag   <= '0;
      e2_data  <= '0;
      rr_ptr   <= 1'b0;
    end else begin
      if (e1_adv) begin
        e1_valid <= |grant;
        if (|grant) begin
          e1_src   <= gnt_src;
          e1_op    <= sel_op;
          e1_tag   <= sel_tag;
          e1_a     <= sel_a;
          e1_b     <= sel_b;
          mul_sign <= (sel_op != OP_MULHU);
          rr_ptr   <= ~gnt_src;
        end
      end
      if (e2_adv) begin
        e2_valid <= e1_valid;
        e2_src   <= e1_src;
        e2_tag   <= e1_tag;
        e2_data  <= e1_result;
      end
      // Flush overrides both valid bits; grant is already suppressed this cycle.
      if (flush) begin
        e1_valid <= 1'b0;
        e2_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = {e2_valid & e2_src, e2_valid & ~e2_src};
  assign resp_data  = e2_valid ? e2_data : '0;
  assign resp_tag   = e2_valid ? e2_tag  : '0;
  assign busy       = e1_valid | e2_valid;

`ifdef MUL_SCHED_STAT_EN
  logic conflict_hit;

  // A grant is at most one-hot, so any grant with both valid is exactly one grant.
  assign conflict_hit = ((req_valid == 2'b11) && (grant != 2'b00)) ||
                        ((req_valid != 2'b00) && (grant == 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (grant[0])     stat_grant0   <= stat_grant0 + 32'd1;
      if (grant[1])     stat_grant1   <= stat_grant1 + 32'd1;
      if (conflict_hit) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`else
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_conflict = '0;
`endif

endmodule
